// File: rtl/halflife_decay_timer_pkg.sv
// Shared types and helpers for the half-life decay timer.
// No logic of its own; imported by the prescaler and the top.
// The terminal-value helper is the single place that defines "finished".
package halflife_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    DECAY = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest value the terminal helper can describe; callers cast down to WIDTH.
  localparam int unsigned MAX_W = 64;

  // Terminal level for a mode: all-ones when counting up, zero for down/decay.
  // HOLD has no terminal level; callers must gate with has_terminal().
  function automatic logic [MAX_W-1:0] terminal_value(input mode_t m, input int unsigned width);
    logic [MAX_W-1:0] v;
    v = '0;
    if (m == UP) begin
      v = {MAX_W{1'b1}} >> (MAX_W - width);
    end
    return v;
  endfunction

  // HOLD runs forever; every other mode finishes at its terminal level.
  function automatic logic has_terminal(input mode_t m);
    return (m != HOLD);
  endfunction

endpackage

// File: rtl/halflife_decay_timer_prescaler.sv
// Step-rate prescaler: emits a one-cycle step every `period` enabled cycles.
// Latency: step is combinational from the count register (period 1 => every enabled cycle).
// No backpressure; clear has priority over enable, a period of 0 behaves as 1.
module halflife_prescaler
  import halflife_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_period,
  output logic                  o_step
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] w_last;

  // Last count value before a step; period 0 collapses onto period 1.
  always_comb begin
    w_last = '0;
    if (i_period != '0) begin
      w_last = i_period - PRESCALE_W'(1);
    end
  end

  assign o_step = i_enable && (r_cnt == w_last);

  // Count enabled cycles, wrapping to 0 on each step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (o_step) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/halflife_decay_timer.sv
// Half-life timer core: holds a value and steps it (hold/up/down/halve) every period cycles.
// Latency: first step visible period edges after start; all outputs registered.
// No backpressure; load aborts any run, start while running is ignored.
module halflife_decay_timer
  import halflife_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16,
  parameter int ELAPSED_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_in,
  input  logic [PRESCALE_W-1:0] i_period,
  input  logic [1:0]            i_mode,
  input  logic                  i_start,
  output logic [WIDTH-1:0]      o_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ELAPSED_W-1:0]  o_elapsed
);

  state_t                r_state;
  mode_t                 r_mode;
  logic [PRESCALE_W-1:0] r_period;
  logic [WIDTH-1:0]      r_out;
  logic                  r_busy;
  logic                  r_done;
  logic [ELAPSED_W-1:0]  r_elapsed;

  mode_t                 w_mode_in;
  logic [WIDTH-1:0]      w_term_in;
  logic [WIDTH-1:0]      w_term;
  logic [WIDTH-1:0]      w_next;
  logic                  w_start_ok;
  logic                  w_pre_clear;
  logic                  w_pre_en;
  logic                  w_step;

  assign w_mode_in   = mode_t'(i_mode);
  assign w_term_in   = WIDTH'(terminal_value(w_mode_in, WIDTH));
  assign w_term      = WIDTH'(terminal_value(r_mode, WIDTH));
  assign w_start_ok  = i_start && (r_state != RUN);
  assign w_pre_clear = i_load || w_start_ok;
  assign w_pre_en    = (r_state == RUN) && !i_load;

  halflife_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_pre_clear),
    .i_enable (w_pre_en),
    .i_period (r_period),
    .o_step   (w_step)
  );

  // Next value for one step of the latched mode, saturating at both rails.
  always_comb begin
    w_next = r_out;
    case (r_mode)
      UP:      if (r_out != '1) w_next = r_out + WIDTH'(1);
      DOWN:    if (r_out != '0) w_next = r_out - WIDTH'(1);
      DECAY:   w_next = r_out >> 1;
      default: w_next = r_out;
    endcase
  end

  // Run FSM, value register, elapsed counter and one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= HOLD;
      r_period  <= PRESCALE_W'(1);
      r_out     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_elapsed <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_out     <= i_in;
        r_elapsed <= '0;
        r_state   <= IDLE;
        r_busy    <= 1'b0;
      end else if (w_start_ok) begin
        r_mode    <= w_mode_in;
        r_period  <= i_period;
        r_elapsed <= '0;
        if (has_terminal(w_mode_in) && (r_out == w_term_in)) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
      end else if ((r_state == RUN) && w_step) begin
        r_out <= w_next;
        if (r_elapsed != '1) begin
          r_elapsed <= r_elapsed + ELAPSED_W'(1);
        end
        if (has_terminal(r_mode) && (w_next == w_term)) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign o_out     = r_out;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_elapsed = r_elapsed;

endmodule

// File: tb/tb_halflife_decay_timer.sv
// Directed bench for halflife_decay_timer: table-driven decay run plus corner sequences.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// A second instance with a 2-bit elapsed counter covers elapsed saturation.
module tb_halflife_decay_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  din;
  logic [15:0] period;
  logic [1:0]  mode;
  logic        start;

  logic [7:0]  out_a;
  logic        busy_a;
  logic        done_a;
  logic [7:0]  el_a;

  logic [7:0]  out_b;
  logic        busy_b;
  logic        done_b;
  logic [1:0]  el_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  halflife_decay_timer #(.WIDTH(8), .PRESCALE_W(16), .ELAPSED_W(8)) dut (
    .clk(clk), .rst(rst), .i_load(load), .i_in(din), .i_period(period),
    .i_mode(mode), .i_start(start),
    .o_out(out_a), .o_busy(busy_a), .o_done(done_a), .o_elapsed(el_a)
  );

  halflife_decay_timer #(.WIDTH(8), .PRESCALE_W(16), .ELAPSED_W(2)) dut_sat (
    .clk(clk), .rst(rst), .i_load(load), .i_in(din), .i_period(period),
    .i_mode(mode), .i_start(start),
    .o_out(out_b), .o_busy(busy_b), .o_done(done_b), .o_elapsed(el_b)
  );

  typedef struct {
    logic [7:0] exp_out;
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_el;
  } vec_t;

  vec_t decay_tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    din  = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [15:0] p);
    mode   = m;
    period = p;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    int done_seen;
    int busy_seen;

    decay_tbl[0] = '{8'h64, 1'b1, 1'b0, 8'd1};
    decay_tbl[1] = '{8'h32, 1'b1, 1'b0, 8'd2};
    decay_tbl[2] = '{8'h19, 1'b1, 1'b0, 8'd3};
    decay_tbl[3] = '{8'h0C, 1'b1, 1'b0, 8'd4};
    decay_tbl[4] = '{8'h06, 1'b1, 1'b0, 8'd5};
    decay_tbl[5] = '{8'h03, 1'b1, 1'b0, 8'd6};
    decay_tbl[6] = '{8'h01, 1'b1, 1'b0, 8'd7};
    decay_tbl[7] = '{8'h00, 1'b0, 1'b1, 8'd8};

    rst = 1'b1; load = 1'b0; din = '0; period = '0; mode = '0; start = 1'b0;
    #12;
    chk("reset_out", out_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_elapsed", el_a, 0);
    rst = 1'b0;
    tick();

    // Decay from C8 with period 3.
    do_load(8'hC8);
    chk("decay_load_out", out_a, 8'hC8);
    do_start(2'd3, 16'd3);
    chk("decay_start_busy", busy_a, 1);
    chk("decay_start_out", out_a, 8'hC8);
    for (int i = 0; i < 8; i++) begin
      tick();
      tick();
      chk("decay_between_steps", out_a, (i == 0) ? 32'hC8 : 32'(decay_tbl[i-1].exp_out));
      tick();
      chk("decay_out", out_a, decay_tbl[i].exp_out);
      chk("decay_busy", busy_a, decay_tbl[i].exp_busy);
      chk("decay_done", done_a, decay_tbl[i].exp_done);
      chk("decay_elapsed", el_a, decay_tbl[i].exp_el);
    end
    tick();
    chk("decay_done_drop", done_a, 0);
    chk("decay_hold_out", out_a, 0);
    chk("decay_hold_elapsed", el_a, 8);

    // Count up to saturation with period 0 (treated as 1).
    do_load(8'hFD);
    do_start(2'd1, 16'd0);
    chk("up_start_busy", busy_a, 1);
    chk("up_start_out", out_a, 8'hFD);
    tick();
    chk("up_step1", out_a, 8'hFE);
    chk("up_step1_done", done_a, 0);
    tick();
    chk("up_step2", out_a, 8'hFF);
    chk("up_done", done_a, 1);
    chk("up_busy_drop", busy_a, 0);
    chk("up_elapsed", el_a, 2);
    tick();
    chk("up_done_drop", done_a, 0);
    chk("up_stays", out_a, 8'hFF);

    // Start with value already terminal: straight to DONE.
    do_load(8'h00);
    do_start(2'd2, 16'd5);
    chk("term_done", done_a, 1);
    chk("term_busy", busy_a, 0);
    chk("term_elapsed", el_a, 0);
    tick();
    chk("term_done_drop", done_a, 0);
    chk("term_busy_after", busy_a, 0);

    // Abort a decay run with load after the second step.
    do_load(8'h80);
    do_start(2'd3, 16'd4);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_pre_out", out_a, 8'h20);
    done_seen = 0;
    load = 1'b1;
    din  = 8'h55;
    tick();
    load = 1'b0;
    chk("abort_out", out_a, 8'h55);
    chk("abort_busy", busy_a, 0);
    chk("abort_elapsed", el_a, 0);
    for (int i = 0; i < 6; i++) begin
      if (done_a) done_seen++;
      tick();
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle_out", out_a, 8'h55);
    chk("abort_idle_busy", busy_a, 0);

    // Hold mode on the 2-bit elapsed instance.
    do_load(8'h5A);
    do_start(2'd0, 16'd1);
    busy_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_b) busy_seen++;
      if (done_b) done_seen++;
    end
    chk("hold_out", out_b, 8'h5A);
    chk("hold_elapsed_sat", el_b, 3);
    chk("hold_busy_cycles", busy_seen, 10);
    chk("hold_no_done", done_seen, 0);
    chk("hold_wide_elapsed", el_a, 10);

    // Asynchronous reset between edges during a down count.
    do_load(8'h10);
    do_start(2'd2, 16'd2);
    tick();
    tick();
    chk("arst_pre_out", out_a, 8'h0F);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", out_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_elapsed", el_a, 0);
    #1;
    rst = 1'b0;
    tick();
    do_start(2'd2, 16'd3);
    chk("arst_restart_done", done_a, 1);
    chk("arst_restart_busy", busy_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
